// File: rtl/get_1hz.sv
// ---------------------------------------------------------------------------
// get_1hz
//   Divides the input clock down to a low-rate enable pulse and a matching
//   square wave. The division ratio DIV is CLK_FREQ_HZ / OUT_FREQ_HZ
//   (truncated), or SIM_DIV when the macro GET_1HZ_SIM_FAST_EN is defined
//   (short periods for simulation). DIV below 2 stops elaboration.
//
// Ports
//   clk  in   sole clock, rising edge
//   rst  in   synchronous, active-high reset
//   enb  out  registered one-cycle pulse, once every DIV cycles
//   sq   out  registered square wave, high while cnt < DIV/2
// ---------------------------------------------------------------------------
module get_1hz #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OUT_FREQ_HZ = 1,
    parameter int unsigned SIM_DIV     = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic enb,
    output logic sq
);

`ifdef GET_1HZ_SIM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // A zero output rate yields DIV = 0, which the check below rejects.
    localparam int unsigned RATIO_DIV = (OUT_FREQ_HZ == 0) ? 0 : CLK_FREQ_HZ / OUT_FREQ_HZ;
    localparam int unsigned DIV       = FAST ? SIM_DIV : RATIO_DIV;

    // Width clamped to 1 only so an illegal DIV reaches the fatal check
    // instead of tripping over a zero-width vector first.
    localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "get_1hz: division ratio DIV=%0d is below 2", DIV);
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          enb_nxt;
    logic          sq_nxt;

    // Wrap on the terminal count so cnt never reaches DIV, even when DIV
    // is not a power of two.
    always_comb begin
        cnt_nxt = '0;
        if (cnt != LAST) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // enb looks at the current count, so it rises on the edge where cnt
    // wraps back to 0; sq looks at the count being loaded, so it tracks the
    // registered cnt without a cycle of lag.
    always_comb begin
        enb_nxt = (cnt == LAST);
        sq_nxt  = (cnt_nxt < HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            enb <= 1'b0;
            sq  <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            enb <= enb_nxt;
            sq  <= sq_nxt;
        end
    end

endmodule

// File: tb/tb_get_1hz.sv
// ---------------------------------------------------------------------------
// tb_get_1hz
//   Self-checking bench for get_1hz. Three instances (DIV = 10, 3, 2) share
//   one clock and reset. A reference model tracks, per instance, the number
//   of non-reset edges since the last reset and derives enb/sq from it with
//   modulo arithmetic. With GET_1HZ_SIM_FAST_EN defined, an extra
//   default-frequency instance with SIM_DIV = 500 is checked for pulse count
//   and spacing.
// ---------------------------------------------------------------------------
module tb_get_1hz;

    logic clk;
    logic rst;
    logic enb10, sq10;
    logic enb3,  sq3;
    logic enb2,  sq2;

    int passed = 0;
    int total  = 0;

    // Reference model state: edges since last reset, per instance.
    int dv [3] = '{10, 3, 2};
    int k  [3] = '{0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    get_1hz #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1), .SIM_DIV(10)) u10 (
        .clk(clk), .rst(rst), .enb(enb10), .sq(sq10)
    );
    get_1hz #(.CLK_FREQ_HZ(7), .OUT_FREQ_HZ(2), .SIM_DIV(3)) u3 (
        .clk(clk), .rst(rst), .enb(enb3), .sq(sq3)
    );
    get_1hz #(.CLK_FREQ_HZ(5), .OUT_FREQ_HZ(2), .SIM_DIV(2)) u2 (
        .clk(clk), .rst(rst), .enb(enb2), .sq(sq2)
    );

`ifdef GET_1HZ_SIM_FAST_EN
    logic enbf, sqf;
    get_1hz #(.SIM_DIV(500)) uf (
        .clk(clk), .rst(rst), .enb(enbf), .sq(sqf)
    );
`endif

    typedef struct {
        logic rst;
        logic enb;
        logic sq;
    } vec_t;

    vec_t tbl [33];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Apply rst for one edge, sample 1 ns after it, advance the model.
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) k[i] = r ? 0 : k[i] + 1;
    endtask

    function automatic logic model_enb(input int i);
        return (k[i] > 0) && (k[i] % dv[i] == 0);
    endfunction

    function automatic logic model_sq(input int i);
        return (k[i] % dv[i]) < (dv[i] / 2);
    endfunction

    task automatic check_model();
        check("m_enb10", enb10, model_enb(0));
        check("m_sq10",  sq10,  model_sq(0));
        check("m_enb3",  enb3,  model_enb(1));
        check("m_sq3",   sq3,   model_sq(1));
        check("m_enb2",  enb2,  model_enb(2));
        check("m_sq2",   sq2,   model_sq(2));
    endtask

    initial begin
        rst = 1'b1;

        // DIV=10 table: 3 reset cycles, then 30 cycles after release.
        // enb high at post-release cycles 10, 20, 30; sq low on 5..9 of each period.
        for (int i = 0; i < 3; i++) tbl[i] = '{rst: 1'b1, enb: 1'b0, sq: 1'b1};
        for (int c = 1; c <= 30; c++) begin
            tbl[2 + c].rst = 1'b0;
            tbl[2 + c].enb = (c == 10 || c == 20 || c == 30);
            tbl[2 + c].sq  = !((c % 10) >= 5);
        end

        for (int i = 0; i < 33; i++) begin
            tick(tbl[i].rst);
            check("tbl_enb10", enb10, tbl[i].enb);
            check("tbl_sq10",  sq10,  tbl[i].sq);
            check_model();
        end

        // Reset on the cycle before the pulse: pulse suppressed, period restarts.
        tick(1'b1);
        for (int c = 1; c <= 8; c++) tick(1'b0);
        tick(1'b1);
        check("midrst_enb10", enb10, 1'b0);
        check("midrst_sq10",  sq10,  1'b1);
        for (int c = 1; c <= 10; c++) begin
            tick(1'b0);
            check("after_rst_enb10", enb10, (c == 10));
        end

        // DIV=3: enb 0,0,1 repeating; sq high only while cnt is 0.
        tick(1'b1);
        check("rst_enb3", enb3, 1'b0);
        check("rst_sq3",  sq3,  1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick(1'b0);
            check("div3_enb", enb3, (c % 3 == 0));
            check("div3_sq",  sq3,  (c % 3 == 0));
            check("div2_enb", enb2, (c % 2 == 0));
            check("div2_sq",  sq2,  (c % 2 == 0));
        end

        // Randomized reset pattern against the model.
        for (int n = 0; n < 1500; n++) begin
            tick(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
            check_model();
        end

`ifdef GET_1HZ_SIM_FAST_EN
        begin
            int cnt_p;
            int last_c;
            cnt_p  = 0;
            last_c = 0;
            tick(1'b1);
            for (int c = 1; c <= 2000; c++) begin
                tick(1'b0);
                if (enbf === 1'b1) begin
                    cnt_p++;
                    if (cnt_p == 1) check_int("fast_first", c, 500);
                    else            check_int("fast_spacing", c - last_c, 500);
                    last_c = c;
                end
            end
            check_int("fast_count", cnt_p, 4);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
